serial_bit_tx: RTL and testbench

Parallel-to-serial transmitter that drives the `data`/`en` capture interface of the team's enable-gated flip-flop stages. A word is accepted over a valid/ready handshake, then shifted out one bit per clock with a qualifying enable strobe, so a downstream enabled flip-flop or shift chain captures exactly the intended bits. The block sits between a word-wide producer and the bit-serial storage path. It also frames words with a last-bit marker and a programmable idle gap.

---
 rtl/serial_bit_pkg.sv | 5 +
 rtl/serial_bit_tx.sv | 97 +++++++++
 tb/tb_serial_bit_tx.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/serial_bit_pkg.sv
// serial_bit_pkg: shared state encoding and constants for the bit-serial transmitter
package serial_bit_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} ser_tx_state_t;
    localparam int SER_GAP_CNT_W = 4;
endpackage

// File: rtl/serial_bit_tx.sv
// serial_bit_tx: word-to-bit serialiser driving data/en of enable-gated flip-flop chains
module serial_bit_tx
    import serial_bit_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             ser_data,
    output logic             ser_en,
    output logic             ser_last,
    output logic             busy
);
    localparam int BCW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [SER_GAP_CNT_W-1:0] GAP_LAST = SER_GAP_CNT_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    ser_tx_state_t state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [SER_GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic ser_data_d, ser_en_d, ser_last_d, busy_d;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign tx_ready = (state_q == ST_IDLE) && !reset;

    // The register always presents the next bit at its head, so outputs are computed from the d-side value.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        ser_data_d = 1'b0;
        ser_en_d   = 1'b0;
        ser_last_d = 1'b0;
        if (reset) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (tx_valid) begin
                    state_d    = ST_SHIFT;
                    sr_d       = tx_data;
                    bit_cnt_d  = '0;
                    ser_en_d   = 1'b1;
                    ser_data_d = head(tx_data);
                    ser_last_d = WIDTH == 1;
                end
                ST_SHIFT: if (bit_cnt_q == BIT_LAST) begin
                    state_d   = GAP_CYCLES > 0 ? ST_GAP : ST_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    sr_d       = MSB_FIRST ? sr_q << 1 : sr_q >> 1;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    ser_en_d   = 1'b1;
                    ser_data_d = head(sr_d);
                    ser_last_d = bit_cnt_d == BIT_LAST;
                end
                ST_GAP: begin
                    state_d   = gap_cnt_q == GAP_LAST ? ST_IDLE : ST_GAP;
                    gap_cnt_d = gap_cnt_q == GAP_LAST ? gap_cnt_q : gap_cnt_q + 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = state_d != ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            ser_data  <= 1'b0;
            ser_en    <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ser_data  <= ser_data_d;
            ser_en    <= ser_en_d;
            ser_last  <= ser_last_d;
            busy      <= busy_d;
        end
    end
endmodule

// File: tb/tb_serial_bit_tx.sv
// tb_serial_bit_tx: three configurations share one stimulus stream, each checked by a per-cycle queue model
module tb_serial_bit_tx;
    logic clk, reset, tx_valid, chk_on;
    logic [7:0] tx_data;
    logic [7:0] ch0, ch1;
    int n_tests = 0, n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int W = g == 2 ? 1 : 8;
        localparam bit M = g != 1;
        localparam int G = g == 0 ? 1 : g == 1 ? 0 : 2;
        logic rdy, sd, se, sl, bz;
        logic [3:0] q[$];
        logic [3:0] cur = 4'b0;

        serial_bit_tx #(.WIDTH(W), .MSB_FIRST(M), .GAP_CYCLES(G)) dut (
            .clk(clk), .reset(reset), .tx_data(tx_data[W-1:0]), .tx_valid(tx_valid),
            .tx_ready(rdy), .ser_data(sd), .ser_en(se), .ser_last(sl), .busy(bz)
        );

        // Each queued entry is one future cycle of {busy, en, data, last}.
        always @(posedge clk) begin
            if (reset) begin
                q.delete();
                cur = 4'b0;
            end else begin
                if (q.size() == 0 && !cur[3] && tx_valid) begin
                    for (int i = 0; i < W; i++)
                        q.push_back({2'b11, tx_data[M ? W - 1 - i : i], i == W - 1});
                    for (int i = 0; i < G; i++) q.push_back(4'b1000);
                end
                cur = q.size() > 0 ? q.pop_front() : 4'b0;
            end
        end

        always @(negedge clk) if (chk_on) begin
            chk($sformatf("c%0d_out", g), {28'b0, bz, se, sd, sl}, {28'b0, cur});
            chk($sformatf("c%0d_rdy", g), {31'b0, rdy}, {31'b0, q.size() == 0 && !cur[3] && !reset});
        end
    end

    always @(posedge clk) begin
        if (cfg[0].se) ch0 <= {ch0[6:0], cfg[0].sd};
        if (cfg[1].se) ch1 <= {cfg[1].sd, ch1[7:1]};
    end

    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = ~d;
    endtask

    initial begin
        logic [7:0] w;
        int rises[$];
        logic prev;
        reset = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5; chk_on = 1'b0;
        @(posedge clk);
        #1 chk_on = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'b0, cfg[0].rdy}, 0);
        chk("rst_outs", {28'b0, cfg[0].bz, cfg[0].se, cfg[0].sd, cfg[0].sl}, 0);
        @(posedge clk);
        #1 reset = 1'b0; tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_noword", {31'b0, cfg[0].se}, 0);
        end
        chk("rst_ready_after", {31'b0, cfg[0].rdy}, 1);

        send(8'hA5);
        w = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("a5_en", {31'b0, cfg[0].se}, 1);
            chk("a5_bit", {31'b0, cfg[0].sd}, {31'b0, w[7-i]});
            chk("a5_last", {31'b0, cfg[0].sl}, {31'b0, i == 7});
        end
        @(negedge clk);
        chk("a5_gap", {29'b0, cfg[0].rdy, cfg[0].se, cfg[0].bz}, 32'b001);
        chk("cap_a5_gap", {24'b0, ch0}, 32'hA5);
        @(negedge clk);
        chk("a5_ready", {31'b0, cfg[0].rdy}, 1);
        chk("cap_a5", {24'b0, ch0}, 32'hA5);

        send(8'h01);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("lsb_bit", {31'b0, cfg[1].sd}, {31'b0, i == 0});
            chk("lsb_en", {31'b0, cfg[1].se}, 1);
        end
        @(negedge clk);
        chk("cap_lsb", {24'b0, ch1}, 32'h01);
        repeat (2) @(negedge clk);

        tx_data = 8'hFF; tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_data = 8'h00;
        prev = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (cfg[0].se && !prev) rises.push_back(k);
            prev = cfg[0].se;
            if (k == 9) chk("b2b_w1", {24'b0, ch0}, 32'hFF);
            if (k == 10) begin
                @(posedge clk);
                #1 tx_valid = 1'b0;
            end
        end
        chk("b2b_rises", rises.size(), 2);
        chk("b2b_gap", rises.size() == 2 ? rises[1] - rises[0] : 0, 10);
        repeat (12) @(negedge clk);
        chk("b2b_w2", {24'b0, ch0}, 32'h00);

        send(8'hF0);
        w = 8'hF0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("f0_bit", {31'b0, cfg[0].sd}, {31'b0, w[7-i]});
        end
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midrst_outs", {28'b0, cfg[0].bz, cfg[0].se, cfg[0].sd, cfg[0].sl}, 0);
        chk("midrst_ready", {31'b0, cfg[0].rdy}, 0);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_idle", {30'b0, cfg[0].rdy, cfg[0].bz}, 32'b10);
        send(8'h3C);
        w = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("3c_bit", {30'b0, cfg[0].se, cfg[0].sd}, {30'b0, 1'b1, w[7-i]});
            chk("3c_last", {31'b0, cfg[0].sl}, {31'b0, i == 7});
        end
        @(negedge clk);
        chk("cap_3c", {24'b0, ch0}, 32'h3C);
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
